tap_recorder: RTL and testbench
===============================

Name: tap_recorder

Overview:
- ZX Spectrum tape recorder/decoder: samples the `ear` line and measures half-periods between edges. It recognises pilot, sync and bit pulses, and assembles bytes.
- It writes each block into tape memory in TAP layout: 2-byte little-endian length, then data bytes.
- It is the receive counterpart of the tape player. Its output image can be replayed by the player unchanged.
- It runs in the 3.5 MHz tape clock domain and shares the tape RAM write port.

Parameters:
- PILOT_MIN, 1900, minimum pilot half-period in clocks.
- PILOT_MAX, 2500, maximum pilot half-period in clocks.
- PILOT_COUNT, 256, consecutive pilot halves required before sync is accepted.
- SYNC_MAX, 800, a half-period below this counts as a sync half.
- BIT_THRESH, 2565, a bit-pair sum (two halves) at or above this decodes as 1, below as 0.
- BIT_MAX, 2000, a single bit half above this is a framing error.
- TIMEOUT, 35000, clocks without an edge that end the block (10 ms).

Ports:
- clock  in  1  3.5 MHz tape clock
- reset_n  in  1  asynchronous active-low reset
- rec  in  1  1 = recording enabled
- ear  in  1  raw tape input, asynchronous
- tap_address  out  16  RAM write address
- tap_wdata  out  8  RAM write data
- tap_we  out  1  single-cycle write strobe
- busy  out  1  1 while a block is in progress (SYNC2 through CLOSE)
- block_count  out  8  number of closed blocks, wraps at 255→0
- err  out  1  sticky memory-overflow flag, cleared only by reset

Behaviour:
- Reset values: every output 0; base 0; FSM in IDLE; all counters 0.
- Input conditioning: 2-FF synchroniser on `ear`, then edge detect.
- Half-period measurement: a 16-bit counter, saturating at FFFF, restarts on every edge. The measured value is valid for one cycle at the edge.
- Write port: `tap_we` pulses for exactly one cycle with `tap_address`/`tap_wdata` valid. There is no backpressure.

FSM states and transitions:
- IDLE: wait for rec=1, then go to PILOT with pilot count 0.
- PILOT, on each edge:
  - measured half in [PILOT_MIN, PILOT_MAX]: pilot count +1, saturating at PILOT_COUNT;
  - half < SYNC_MAX and count == PILOT_COUNT: go to SYNC2;
  - any other half: count resets to 0.
- SYNC2, on the next edge:
  - half < SYNC_MAX: go to BIT_A; len=0; bitn=7; data address = base+2;
  - otherwise: back to PILOT with count 0.
- BIT_A: the next edge latches half A.
- BIT_B: the next edge provides half B.
  - Bit value = (A+B >= BIT_THRESH); shift MSB-first.
  - After 8 bits: write the byte at base+2+len, len+1, then return to BIT_A.
  - A or B > BIT_MAX goes to CLOSE. The current partial byte is discarded.
- CLOSE, entered on timeout (counter reaches TIMEOUT in BIT_A/BIT_B), framing error, or rec=0 mid-block:
  - len == 0: no writes; go to PILOT (or IDLE if rec=0).
  - len > 0: cycle 1 writes len[7:0] at base; cycle 2 writes len[15:8] at base+1.
  - Then base <= base+2+len, block_count +1, go to PILOT (or IDLE if rec=0).
- Overflow: a data byte whose address would exceed FFFF is not written. Instead err=1, the block is closed at its current length, and the FSM goes to IDLE. It stays in IDLE until reset.
- rec=0 in IDLE/PILOT/SYNC2: go to IDLE immediately; nothing is written.
- Asynchronous reset mid-block: an unfinished block leaves no length header. Base returns to 0.
- Timeout in PILOT/SYNC2: pilot count resets to 0; no other effect.

Decomposition:
- Shared package `tap_pkg`, common with the player:
  - nominal timing constants: PILOT_PERIOD 2168, PILOT_HEADER 8064, PILOT_DATA 3224, SYNC_HI 667, SYNC_LO 735, SIGNAL_0 855, SIGNAL_1 1710;
  - the recorder threshold defaults, derived from those constants;
  - the FSM state enum.
- One sub-module, `tap_pulse_meter`: synchroniser, edge detect, saturating 16-bit half-period counter, and timeout flag. Outputs: `edge`, `period[15:0]`, `tmo`.

Test Plan:
- Header block: drive 8064 halves of 2168, sync 667/735, then 19 bytes (flag 00), then silence. Expected: 19 data writes at 0002..0014; length 13h at 0000, 00h at 0001; block_count=1; next block base 0015h.
- Bit decode: byte A5h with halves of 855/1710 at ±10% jitter. Expected: byte A5h written.
- Short pilot: 100 pilot halves, sync, then data. Expected: no writes; FSM stays in PILOT; recording succeeds once a proper 3224-half pilot follows.
- Framing error: 3 bytes, then a 3000-clock half mid-byte. Expected: 3 data writes; length 0003h written; the partial byte is never written.
- rec=0 after 2 bytes, then rec=1 with a full second block. Expected: block 1 closed with length 0002h; block 2 header at 0004h.
- Overflow: data address reaches FFFF and another byte arrives. Expected: err=1; header written with the length so far; FSM in IDLE; no further tap_we until reset.

Source files
------------

// File: rtl/tap_pkg.sv
// Shared tape definitions for the player and the recorder: nominal ROM loader
// timing in 3.5 MHz clocks, the recorder's decode thresholds and the recorder FSM states.
package tap_pkg;

  localparam int TAPE_CLK_HZ  = 3_500_000;

  localparam int PILOT_PERIOD = 2168;
  localparam int PILOT_HEADER = 8064;
  localparam int PILOT_DATA   = 3224;
  localparam int SYNC_HI      = 667;
  localparam int SYNC_LO      = 735;
  localparam int SIGNAL_0     = 855;
  localparam int SIGNAL_1     = 1710;

  // Acceptance windows are centred on the nominal pulses. A bit is decided on
  // the pair sum, and the threshold sits midway between 2*SIGNAL_0 and 2*SIGNAL_1.
  localparam int REC_PILOT_MIN   = PILOT_PERIOD - 268;
  localparam int REC_PILOT_MAX   = PILOT_PERIOD + 332;
  localparam int REC_PILOT_COUNT = 256;
  localparam int REC_SYNC_MAX    = SYNC_LO + 65;
  localparam int REC_BIT_THRESH  = SIGNAL_0 + SIGNAL_1;
  localparam int REC_BIT_MAX     = SIGNAL_1 + 290;
  localparam int REC_TIMEOUT     = TAPE_CLK_HZ / 100;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PILOT,
    ST_SYNC2,
    ST_BIT_A,
    ST_BIT_B,
    ST_CLOSE_LO,
    ST_CLOSE_HI
  } tap_state_t;

endpackage

// File: rtl/tap_pulse_meter.sv
// Conditions the raw ear line and measures the time between its edges, flagging
// when the line has been quiet for TIMEOUT clocks.
module tap_pulse_meter
  import tap_pkg::*;
#(
  parameter int TIMEOUT = REC_TIMEOUT
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ear,
  output logic        pulse_edge,
  output logic [15:0] period,
  output logic        tmo
);

  localparam logic [15:0] TMO_CLKS = 16'(TIMEOUT);

  logic        ear_s1;
  logic        ear_s2;
  logic        ear_d;
  logic [15:0] cnt;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // cnt holds the clocks elapsed since the last edge, so at an edge it is the half-period.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ear_s1 <= 1'b0;
      ear_s2 <= 1'b0;
      ear_d  <= 1'b0;
      cnt    <= 16'd0;
    end else begin
      ear_s1 <= ear;
      ear_s2 <= ear_s1;
      ear_d  <= ear_s2;
      cnt    <= (ear_s2 ^ ear_d) ? 16'd1 : sat_inc(cnt);
    end
  end

  assign pulse_edge = ear_s2 ^ ear_d;
  assign period     = cnt;
  assign tmo        = cnt >= TMO_CLKS;

endmodule

// File: rtl/tap_recorder.sv
// Decodes ROM-loader tape signals from the ear line and stores each block in
// tape RAM in TAP layout: a 2-byte little-endian length, then the data bytes.
module tap_recorder
  import tap_pkg::*;
#(
  parameter int          PILOT_MIN   = REC_PILOT_MIN,
  parameter int          PILOT_MAX   = REC_PILOT_MAX,
  parameter int          PILOT_COUNT = REC_PILOT_COUNT,
  parameter int          SYNC_MAX    = REC_SYNC_MAX,
  parameter int          BIT_THRESH  = REC_BIT_THRESH,
  parameter int          BIT_MAX     = REC_BIT_MAX,
  parameter int          TIMEOUT     = REC_TIMEOUT,
  parameter logic [15:0] MEM_TOP     = 16'hFFFF
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        rec,
  input  logic        ear,
  output logic [15:0] tap_address,
  output logic [7:0]  tap_wdata,
  output logic        tap_we,
  output logic        busy,
  output logic [7:0]  block_count,
  output logic        err
);

  localparam logic [15:0] P_MIN = 16'(PILOT_MIN);
  localparam logic [15:0] P_MAX = 16'(PILOT_MAX);
  localparam logic [15:0] P_CNT = 16'(PILOT_COUNT);
  localparam logic [15:0] S_MAX = 16'(SYNC_MAX);
  localparam logic [15:0] B_MAX = 16'(BIT_MAX);
  localparam logic [16:0] B_THR = 17'(BIT_THRESH);

  logic        pulse_edge;
  logic        tmo;
  logic [15:0] period;

  tap_pulse_meter #(.TIMEOUT(TIMEOUT)) u_meter (
    .clock      (clock),
    .reset_n    (reset_n),
    .ear        (ear),
    .pulse_edge (pulse_edge),
    .period     (period),
    .tmo        (tmo)
  );

  tap_state_t  state;
  logic [15:0] pilot_cnt;
  logic [15:0] len;
  logic [15:0] half_a;
  logic [16:0] base;
  logic [2:0]  bitn;
  logic [6:0]  shreg;

  logic [16:0] data_addr;
  logic [16:0] pair_sum;
  logic [7:0]  byte_val;
  logic        pilot_ok;
  logic        sync_ok;
  logic        long_half;
  tap_state_t  after_close;

  // base is one bit wider than the bus so that a block ending exactly at the top
  // of memory leaves the next block pointing past it rather than wrapping to 0.
  assign data_addr   = base + 17'd2 + {1'b0, len};
  assign pair_sum    = {1'b0, half_a} + {1'b0, period};
  assign byte_val    = {shreg, pair_sum >= B_THR};
  assign pilot_ok    = (period >= P_MIN) && (period <= P_MAX);
  assign sync_ok     = period < S_MAX;
  assign long_half   = period > B_MAX;
  assign after_close = (rec && !err) ? ST_PILOT : ST_IDLE;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= ST_IDLE;
      pilot_cnt   <= 16'd0;
      len         <= 16'd0;
      half_a      <= 16'd0;
      base        <= 17'd0;
      bitn        <= 3'd0;
      shreg       <= 7'd0;
      tap_address <= 16'd0;
      tap_wdata   <= 8'd0;
      tap_we      <= 1'b0;
      busy        <= 1'b0;
      block_count <= 8'd0;
      err         <= 1'b0;
    end else begin
      tap_we <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (rec && !err) begin
            state     <= ST_PILOT;
            pilot_cnt <= 16'd0;
          end
        end

        ST_PILOT: begin
          if (!rec) begin
            state <= ST_IDLE;
          end else if (tmo) begin
            pilot_cnt <= 16'd0;
          end else if (pulse_edge) begin
            if (pilot_ok) begin
              pilot_cnt <= (pilot_cnt == P_CNT) ? P_CNT : pilot_cnt + 16'd1;
            end else if (sync_ok && pilot_cnt == P_CNT) begin
              state <= ST_SYNC2;
              busy  <= 1'b1;
            end else begin
              pilot_cnt <= 16'd0;
            end
          end
        end

        ST_SYNC2: begin
          if (!rec) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (pulse_edge) begin
            pilot_cnt <= 16'd0;
            if (sync_ok) begin
              state <= ST_BIT_A;
              len   <= 16'd0;
              bitn  <= 3'd7;
            end else begin
              state <= ST_PILOT;
              busy  <= 1'b0;
            end
          end else if (tmo) begin
            pilot_cnt <= 16'd0;
          end
        end

        ST_BIT_A: begin
          if (!rec || tmo) begin
            state <= ST_CLOSE_LO;
          end else if (pulse_edge) begin
            if (long_half) begin
              state <= ST_CLOSE_LO;
            end else begin
              half_a <= period;
              state  <= ST_BIT_B;
            end
          end
        end

        ST_BIT_B: begin
          if (!rec || tmo) begin
            state <= ST_CLOSE_LO;
          end else if (pulse_edge) begin
            if (long_half) begin
              state <= ST_CLOSE_LO;
            end else begin
              shreg <= byte_val[6:0];
              state <= ST_BIT_A;
              if (bitn != 3'd0) begin
                bitn <= bitn - 3'd1;
              end else if (data_addr > {1'b0, MEM_TOP}) begin
                err   <= 1'b1;
                state <= ST_CLOSE_LO;
              end else begin
                tap_we      <= 1'b1;
                tap_address <= data_addr[15:0];
                tap_wdata   <= byte_val;
                len         <= len + 16'd1;
                bitn        <= 3'd7;
              end
            end
          end
        end

        // An empty block leaves memory and base untouched.
        ST_CLOSE_LO: begin
          if (len == 16'd0) begin
            state     <= after_close;
            busy      <= 1'b0;
            pilot_cnt <= 16'd0;
          end else begin
            tap_we      <= 1'b1;
            tap_address <= base[15:0];
            tap_wdata   <= len[7:0];
            state       <= ST_CLOSE_HI;
          end
        end

        ST_CLOSE_HI: begin
          tap_we      <= 1'b1;
          tap_address <= base[15:0] + 16'd1;
          tap_wdata   <= len[15:8];
          base        <= data_addr;
          block_count <= block_count + 8'd1;
          state       <= after_close;
          busy        <= 1'b0;
          pilot_cnt   <= 16'd0;
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tap_recorder.sv
// Directed bench for tap_recorder with timing scaled down about 40x so every
// scenario fits a short run; memory top is lowered so overflow is reachable.
module tb_tap_recorder;

  localparam int          PH     = 50;
  localparam int          P_MIN  = 44;
  localparam int          P_MAX  = 58;
  localparam int          P_CNT  = 16;
  localparam int          S_MAX  = 12;
  localparam int          THRESH = 60;
  localparam int          B_MAX  = 50;
  localparam int          TMO    = 400;
  localparam logic [15:0] TOP    = 16'h0017;
  localparam int          S0     = 20;
  localparam int          S1     = 40;

  logic        clock;
  logic        reset_n;
  logic        rec;
  logic        ear;
  logic [15:0] tap_address;
  logic [7:0]  tap_wdata;
  logic        tap_we;
  logic        busy;
  logic [7:0]  block_count;
  logic        err;

  tap_recorder #(
    .PILOT_MIN   (P_MIN),
    .PILOT_MAX   (P_MAX),
    .PILOT_COUNT (P_CNT),
    .SYNC_MAX    (S_MAX),
    .BIT_THRESH  (THRESH),
    .BIT_MAX     (B_MAX),
    .TIMEOUT     (TMO),
    .MEM_TOP     (TOP)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .rec         (rec),
    .ear         (ear),
    .tap_address (tap_address),
    .tap_wdata   (tap_wdata),
    .tap_we      (tap_we),
    .busy        (busy),
    .block_count (block_count),
    .err         (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] addr;
    logic [7:0]  data;
  } wr_t;

  wr_t        expq[$];
  wr_t        got;
  logic [7:0] cap [0:63];
  logic [7:0] tx  [0:31];
  int         exp_base;
  int         exp_bc;
  int         exp_err;
  int         n_tests;
  int         n_fail;

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Model of the tape image: bytes land after a 2-byte length slot; a byte past
  // the top of memory ends the block and latches the error for good.
  task automatic model_block(input int n);
    int blen;
    int a;
    blen = 0;
    if (exp_err != 0) return;
    for (int i = 0; i < n; i++) begin
      a = exp_base + 2 + i;
      if (a > int'(TOP)) begin
        exp_err = 1;
        break;
      end
      expq.push_back('{addr: 16'(a), data: tx[i]});
      blen++;
    end
    if (blen > 0) begin
      expq.push_back('{addr: 16'(exp_base), data: 8'(blen)});
      expq.push_back('{addr: 16'(exp_base + 1), data: 8'(blen >> 8)});
      exp_base = exp_base + 2 + blen;
      exp_bc   = (exp_bc + 1) % 256;
    end
  endtask

  // Every write strobe must match the next write the model predicts.
  always @(negedge clock) begin
    if (reset_n && tap_we) begin
      cap[tap_address[5:0]] = tap_wdata;
      if (expq.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %0h data %0h, expected no write", tap_address, tap_wdata);
      end else begin
        got = expq.pop_front();
        check("write_addr", int'(tap_address), int'(got.addr));
        check("write_data", int'(tap_wdata), int'(got.data));
      end
    end
  end

  task automatic half(input int h);
    repeat (h) @(posedge clock);
    #1 ear = ~ear;
  endtask

  task automatic pilot(input int n);
    for (int i = 0; i < n; i++) half(PH);
  endtask

  task automatic sync_pair();
    half(8);
    half(9);
  endtask

  // Jittered halves stay within +/-10% of the nominal bit pulses.
  task automatic send_byte(input logic [7:0] b, input bit jit);
    for (int i = 7; i >= 0; i--) begin
      if (!jit) begin
        half(b[i] ? S1 : S0);
        half(b[i] ? S1 : S0);
      end else if (b[i]) begin
        half(i[0] ? 36 : 44);
        half(i[1] ? 44 : 38);
      end else begin
        half(i[0] ? 18 : 22);
        half(i[1] ? 22 : 19);
      end
    end
  endtask

  task automatic silence();
    repeat (TMO + 60) @(posedge clock);
    #1;
  endtask

  task automatic check_idle(input string name);
    check({name, "_block_count"}, int'(block_count), exp_bc);
    check({name, "_err"}, int'(err), exp_err);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_writes_done"}, expq.size(), 0);
  endtask

  task automatic do_reset();
    #1;
    reset_n = 1'b0;
    rec     = 1'b0;
    ear     = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    exp_base = 0;
    exp_bc   = 0;
    exp_err  = 0;
    expq.delete();
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $display("[TB] %0d tests run, %0d failed", n_tests + 1, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset_n = 1'b0;
    rec     = 1'b0;
    ear     = 1'b0;
    for (int i = 0; i < 64; i++) cap[i] = 8'h00;
    do_reset();

    check("rst_address", int'(tap_address), 0);
    check("rst_wdata", int'(tap_wdata), 0);
    check("rst_we", int'(tap_we), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_block_count", int'(block_count), 0);
    check("rst_err", int'(err), 0);

    // Header block: flag 00 plus 18 bytes.
    for (int i = 0; i < 19; i++) tx[i] = (i == 0) ? 8'h00 : 8'(i * 37 + 5);
    rec = 1'b1;
    model_block(19);
    pilot(40);
    sync_pair();
    for (int i = 0; i < 19; i++) send_byte(tx[i], 1'b0);
    check("hdr_busy_mid_block", int'(busy), 1);
    silence();
    check_idle("hdr");
    check("hdr_len_lo", int'(cap[0]), 8'h13);
    check("hdr_len_hi", int'(cap[1]), 8'h00);
    check("hdr_flag", int'(cap[2]), 8'h00);
    check("hdr_count", int'(block_count), 1);

    // Jittered bit pulses; the block lands at base 0015h.
    tx[0] = 8'hA5;
    model_block(1);
    pilot(40);
    sync_pair();
    send_byte(8'hA5, 1'b1);
    silence();
    check_idle("jit");
    check("jit_byte", int'(cap[8'h17]), 8'hA5);
    check("jit_len_lo", int'(cap[8'h15]), 8'h01);

    // Short pilot is rejected, a proper pilot then records.
    do_reset();
    rec = 1'b1;
    pilot(5);
    sync_pair();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    repeat (20) @(posedge clock);
    #1;
    check("short_busy", int'(busy), 0);
    check("short_no_write", int'(block_count), 0);
    tx[0] = 8'h3C;
    tx[1] = 8'hC3;
    model_block(2);
    pilot(24);
    sync_pair();
    send_byte(8'h3C, 1'b0);
    send_byte(8'hC3, 1'b0);
    silence();
    check_idle("short");
    check("short_byte0", int'(cap[2]), 8'h3C);

    // Framing error after three bytes and one bit.
    do_reset();
    rec = 1'b1;
    tx[0] = 8'h11;
    tx[1] = 8'h22;
    tx[2] = 8'h33;
    model_block(3);
    pilot(20);
    sync_pair();
    for (int i = 0; i < 3; i++) send_byte(tx[i], 1'b0);
    half(S1);
    half(S1);
    half(150);
    silence();
    check_idle("frame");
    check("frame_len_lo", int'(cap[0]), 8'h03);

    // rec drops after two bytes, then a second full block.
    do_reset();
    rec = 1'b1;
    tx[0] = 8'h5A;
    tx[1] = 8'hA5;
    model_block(2);
    pilot(20);
    sync_pair();
    send_byte(8'h5A, 1'b0);
    send_byte(8'hA5, 1'b0);
    repeat (10) @(posedge clock);
    #1 rec = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    check_idle("recoff1");
    check("recoff1_len", int'(cap[0]), 8'h02);
    rec = 1'b1;
    tx[0] = 8'h77;
    tx[1] = 8'h88;
    model_block(2);
    pilot(20);
    sync_pair();
    send_byte(8'h77, 1'b0);
    send_byte(8'h88, 1'b0);
    silence();
    check_idle("recoff2");
    check("recoff2_hdr", int'(cap[4]), 8'h02);
    check("recoff2_byte", int'(cap[6]), 8'h77);

    // Overflow: 22 bytes fit below the top, the 23rd does not.
    do_reset();
    rec = 1'b1;
    for (int i = 0; i < 23; i++) tx[i] = 8'(i + 1);
    model_block(23);
    pilot(20);
    sync_pair();
    for (int i = 0; i < 23; i++) send_byte(tx[i], 1'b0);
    silence();
    check_idle("ovf");
    check("ovf_err", int'(err), 1);
    check("ovf_len_lo", int'(cap[0]), 8'h16);
    check("ovf_count", int'(block_count), 1);
    rec = 1'b0;
    repeat (5) @(posedge clock);
    #1 rec = 1'b1;
    tx[0] = 8'hFF;
    model_block(1);
    pilot(20);
    sync_pair();
    send_byte(8'hFF, 1'b0);
    silence();
    check_idle("ovf_after");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
